mem_bus_arbiter: RTL

- Shares the CPU-side tagged memory bus (multiplexed o_ad/o_tag with o_astb/o_rd/o_wr strobes) between two burst requesters: requester 0 is the CPU memory unit, requester 1 is the I/O/DMA channel.
- Each granted request becomes one address-strobe cycle followed by 1..16 consecutive read or write beats, using the RAM's auto-incrementing batch mode.
- Arbitration is round-robin at burst granularity.

---
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two requesters share the tagged memory bus. Requester 0 is the CPU memory
// unit and requester 1 is the I/O/DMA channel. Each grant produces one
// address-strobe cycle and then len+1 consecutive read or write beats, using
// the RAM's auto-incrementing batch mode. Ownership alternates round-robin,
// one whole burst at a time.
//
// The bus strobes, gnt and done come only from flops, so there is no
// combinational path from req to the bus. Write data and tags pass straight
// through from the selected requester during write beats. Read data is
// captured at the clock edge that closes each read beat.

module mem_bus_arbiter #(
    parameter int AW = 20,
    parameter int LW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [2*AW-1:0]   addr,
    input  logic [2*LW-1:0]   len,
    input  logic [127:0]      wdata,
    input  logic [15:0]       wtag,
    input  logic [63:0]       i_data,
    input  logic [7:0]        i_tag,
    output logic [1:0]        gnt,
    output logic [1:0]        wack,
    output logic [1:0]        done,
    output logic [1:0]        rvalid,
    output logic [63:0]       rdata,
    output logic [7:0]        rtag,
    output logic [63:0]       o_ad,
    output logic [7:0]        o_tag,
    output logic              o_astb,
    output logic              o_rd,
    output logic              o_wr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_BEAT = 2'd2
    } state_t;

    state_t          state;
    logic            last;
    logic            sel_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   count_q;
    logic            astb_q;
    logic            rd_q;
    logic            wr_q;
    logic            done_q;

    logic            win;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [LW-1:0]   win_len;

    // Pick the winner among the current requests. On a tie, the requester
    // that did not win last time gets the bus.
    always_comb begin
        win      = req[1] & (~req[0] | ~last);
        win_we   = win ? we[1] : we[0];
        win_addr = win ? addr[2*AW-1:AW] : addr[AW-1:0];
        win_len  = win ? len[2*LW-1:LW] : len[LW-1:0];
    end

    // Burst sequencer. The strobe and grant flops are loaded together with
    // the state they belong to, so they are valid in that state's cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            gnt     <= 2'b00;
            astb_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        state   <= S_ADDR;
                        sel_q   <= win;
                        last    <= win;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        count_q <= win_len;
                        gnt     <= win ? 2'b10 : 2'b01;
                        astb_q  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state  <= S_BEAT;
                    astb_q <= 1'b0;
                    rd_q   <= ~we_q;
                    wr_q   <= we_q;
                    done_q <= (count_q == '0);
                end
                S_BEAT: begin
                    if (count_q == '0) begin
                        state  <= S_IDLE;
                        gnt    <= 2'b00;
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        count_q <= count_q - LW'(1);
                        done_q  <= (count_q == LW'(1));
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    gnt    <= 2'b00;
                    astb_q <= 1'b0;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture the read word at the edge that ends each read beat. A reset
    // drops any word that is still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 2'b00;
            rdata  <= '0;
            rtag   <= '0;
        end else begin
            rvalid <= rd_q ? gnt : 2'b00;
            if (rd_q) begin
                rdata <= i_data;
                rtag  <= i_tag;
            end
        end
    end

    // Drive the bus from the registered state. The write word comes straight
    // from the selected requester.
    always_comb begin
        o_astb = astb_q;
        o_rd   = rd_q;
        o_wr   = wr_q;
        wack   = gnt & {2{wr_q}};
        done   = gnt & {2{done_q}};
        o_ad   = '0;
        o_tag  = '0;
        if (astb_q) begin
            o_ad = {{(64-AW){1'b0}}, addr_q};
        end else if (wr_q) begin
            o_ad  = sel_q ? wdata[127:64] : wdata[63:0];
            o_tag = sel_q ? wtag[15:8] : wtag[7:0];
        end
    end

endmodule
